// File: rtl/nlp_update_scheduler.sv
// Next-line-predictor update scheduler: two producer FIFOs, backend-priority arbiter with IF3 anti-starvation.
// Optional build macro NLP_SCHED_COALESCE_EN enables in-place coalescing of same-PC updates.
module nlp_update_scheduler #(
    parameter int QDEPTH       = 4,
    parameter int PC_W         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if3_valid,
    input  logic [PC_W-1:0] if3_pc,
    input  logic [PC_W-1:0] if3_target,
    input  logic [1:0]      if3_bim,
    input  logic            if3_take,
    output logic            if3_ready,
    input  logic            be_valid,
    input  logic [PC_W-1:0] be_pc,
    input  logic [PC_W-1:0] be_target,
    input  logic [1:0]      be_bim,
    input  logic            be_take,
    output logic            be_ready,
    input  logic            flush_if3,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic [1:0]      upd_bim,
    output logic            upd_take,
    output logic            upd_src,
    input  logic            upd_ready,
    output logic [15:0]     drop_cnt
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic [1:0]      bim;
        logic            take;
    } entry_t;

    entry_t            if3_mem [QDEPTH];
    entry_t            be_mem  [QDEPTH];
    logic [QDEPTH-1:0] if3_live;
    logic [PW-1:0]     if3_rd, if3_wr, be_rd, be_wr;
    logic [CW-1:0]     if3_cnt, be_cnt;
    logic [SW-1:0]     starve;

    entry_t            if3_head, be_head, sel;
    logic              if3_push, be_push, if3_ne, if3_avail, be_ne;
    logic              grant_if3, hs, if3_gpop, be_pop, shadow, autodrop, if3_pop;
    logic              if3_hit, be_hit, if3_alloc, be_alloc;
    logic [PW-1:0]     if3_hit_idx, be_hit_idx;
    logic [QDEPTH-1:0] if3_kill;
    logic [CW:0]       drop_inc;
    logic [16:0]       drop_sum;

    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int unsigned i);
        return base + PW'(i);
    endfunction

    assign if3_ready = (if3_cnt != FULL);
    assign be_ready  = (be_cnt != FULL);
    assign if3_push  = if3_valid && if3_ready;
    assign be_push   = be_valid && be_ready;
    assign if3_head  = if3_mem[if3_rd];
    assign be_head   = be_mem[be_rd];

    // A dead (invalidated) IF3 head is never presented; it is retired silently as a drop.
    assign if3_ne    = (if3_cnt != '0);
    assign if3_avail = if3_ne && if3_live[if3_rd];
    assign autodrop  = if3_ne && !if3_live[if3_rd];
    assign be_ne     = (be_cnt != '0);

    assign grant_if3 = if3_avail && (!be_ne || starve == SLIM);
    assign upd_valid = be_ne || if3_avail;
    assign upd_src   = be_ne && !grant_if3;
    assign hs        = upd_valid && upd_ready;
    assign if3_gpop  = hs && grant_if3;
    assign be_pop    = hs && !grant_if3;
    assign shadow    = be_pop && if3_avail && (if3_head.pc == be_head.pc);
    assign if3_pop   = if3_gpop || shadow || autodrop;
    assign if3_alloc = if3_push && !if3_hit;
    assign be_alloc  = be_push && !be_hit;

    always_comb begin
        sel = '0;
        if (grant_if3)  sel = if3_head;
        else if (be_ne) sel = be_head;
        upd_pc     = sel.pc;
        upd_target = sel.target;
        upd_bim    = sel.bim;
        upd_take   = sel.take;
    end

`ifdef NLP_SCHED_COALESCE_EN
    // Scan oldest to youngest so the youngest match wins; an entry leaving this cycle is excluded.
    always_comb begin
        if3_hit     = 1'b0;
        if3_hit_idx = '0;
        be_hit      = 1'b0;
        be_hit_idx  = '0;
        if3_kill    = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (CW'(i) < if3_cnt && !(i == 0 && if3_pop) && if3_live[slot(if3_rd, i)]) begin
                if (if3_mem[slot(if3_rd, i)].pc == if3_pc) begin
                    if3_hit     = 1'b1;
                    if3_hit_idx = slot(if3_rd, i);
                end
                if (be_push && if3_mem[slot(if3_rd, i)].pc == be_pc)
                    if3_kill[slot(if3_rd, i)] = 1'b1;
            end
            if (CW'(i) < be_cnt && !(i == 0 && be_pop) && be_mem[slot(be_rd, i)].pc == be_pc) begin
                be_hit     = 1'b1;
                be_hit_idx = slot(be_rd, i);
            end
        end
    end
`else
    always_comb begin
        if3_hit     = 1'b0;
        if3_hit_idx = '0;
        be_hit      = 1'b0;
        be_hit_idx  = '0;
        if3_kill    = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || flush_if3) begin
            if3_cnt  <= '0;
            if3_rd   <= '0;
            if3_wr   <= '0;
            if3_live <= '0;
        end else begin
            if3_live <= if3_live & ~if3_kill;
            if (if3_alloc) begin
                if3_mem[if3_wr]  <= '{pc: if3_pc, target: if3_target, bim: if3_bim, take: if3_take};
                if3_live[if3_wr] <= 1'b1;
                if3_wr           <= if3_wr + 1'b1;
            end else if (if3_push) begin
                if3_mem[if3_hit_idx].target <= if3_target;
                if3_mem[if3_hit_idx].bim    <= if3_bim;
                if3_mem[if3_hit_idx].take   <= if3_take;
            end
            if (if3_pop) if3_rd <= if3_rd + 1'b1;
            if3_cnt <= if3_cnt + CW'(if3_alloc) - CW'(if3_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            be_cnt <= '0;
            be_rd  <= '0;
            be_wr  <= '0;
        end else begin
            if (be_alloc) begin
                be_mem[be_wr] <= '{pc: be_pc, target: be_target, bim: be_bim, take: be_take};
                be_wr         <= be_wr + 1'b1;
            end else if (be_push) begin
                be_mem[be_hit_idx].target <= be_target;
                be_mem[be_hit_idx].bim    <= be_bim;
                be_mem[be_hit_idx].take   <= be_take;
            end
            if (be_pop) be_rd <= be_rd + 1'b1;
            be_cnt <= be_cnt + CW'(be_alloc) - CW'(be_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !if3_avail || if3_gpop) starve <= '0;
        else if (be_pop && starve != SLIM) starve <= starve + 1'b1;
    end

    // On flush every queued IF3 entry is dropped except a head completing its handshake.
    always_comb begin
        if (flush_if3)
            drop_inc = {1'b0, if3_cnt} - (CW+1)'(if3_gpop) + (CW+1)'(if3_push);
        else
            drop_inc = (CW+1)'(shadow) + (CW+1)'(autodrop);
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (rst)              drop_cnt <= '0;
        else if (drop_sum[16]) drop_cnt <= '1;
        else                  drop_cnt <= drop_sum[15:0];
    end
endmodule

// File: tb/tb_nlp_update_scheduler.sv
// Scoreboard bench for nlp_update_scheduler: directed pushes queue expected updates, a monitor checks handshakes.
module tb_nlp_update_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        if3_valid, be_valid, flush_if3, upd_ready;
    logic [31:0] if3_pc, if3_target, be_pc, be_target;
    logic [1:0]  if3_bim, be_bim;
    logic        if3_take, be_take;
    logic        if3_ready, be_ready, upd_valid, upd_take, upd_src;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_bim;
    logic [15:0] drop_cnt;

    nlp_update_scheduler #(.QDEPTH(4), .PC_W(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if3_valid(if3_valid), .if3_pc(if3_pc), .if3_target(if3_target), .if3_bim(if3_bim),
        .if3_take(if3_take), .if3_ready(if3_ready),
        .be_valid(be_valid), .be_pc(be_pc), .be_target(be_target), .be_bim(be_bim),
        .be_take(be_take), .be_ready(be_ready),
        .flush_if3(flush_if3),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_bim(upd_bim),
        .upd_take(upd_take), .upd_src(upd_src), .upd_ready(upd_ready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  bim;
        logic        take;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input logic src, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [1:0] bim, input logic take);
        exp_t e;
        e.src = src; e.pc = pc; e.target = tgt; e.bim = bim; e.take = take;
        exp_q.push_back(e);
    endtask

    task automatic drive_if3(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic [1:0] bim, input logic take);
        if3_valid = v; if3_pc = pc; if3_target = tgt; if3_bim = bim; if3_take = take;
    endtask

    task automatic drive_be(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic [1:0] bim, input logic take);
        be_valid = v; be_pc = pc; be_target = tgt; be_bim = bim; be_take = take;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d updates outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && upd_valid && upd_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_upd: got pc %0h src %0d, expected no update", upd_pc, upd_src);
            end else begin
                e = exp_q.pop_front();
                chk("upd_src", 32'(upd_src), 32'(e.src));
                chk("upd_pc", upd_pc, e.pc);
                chk("upd_target", upd_target, e.target);
                chk("upd_bim", 32'(upd_bim), 32'(e.bim));
                chk("upd_take", 32'(upd_take), 32'(e.take));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush_if3 = 1'b0; upd_ready = 1'b0;
        drive_if3(0, '0, '0, '0, 0);
        drive_be(0, '0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_upd_valid", 32'(upd_valid), 0);
            chk("idle_if3_ready", 32'(if3_ready), 1);
            chk("idle_be_ready", 32'(be_ready), 1);
            chk("idle_drop_cnt", 32'(drop_cnt), 0);
        end

        // Single IF3 update, latency one cycle
        tick();
        upd_ready = 1'b1;
        drive_if3(1, 32'h100, 32'hA100, 2'b01, 1);
        expect_upd(0, 32'h100, 32'hA100, 2'b01, 1);
        tick();
        if3_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", 32'(upd_valid), 1);
        chk("single_src", 32'(upd_src), 0);
        tick();
        @(negedge clk);
        chk("single_popped", 32'(upd_valid), 0);

        // Both FIFOs full, then starvation-guarded drain order
        tick();
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_if3(1, 32'h2000 + 32'(4 * i), 32'hB000 + 32'(i), 2'(i), i[0]);
            drive_be(1, 32'h1000 + 32'(4 * i), 32'hC000 + 32'(i), 2'(3 - i), ~i[0]);
            tick();
        end
        drive_if3(1, 32'hDEAD, 32'hDEAD, 2'b11, 1);
        drive_be(1, 32'hBEEF, 32'hBEEF, 2'b11, 1);
        @(negedge clk);
        chk("full_if3_ready", 32'(if3_ready), 0);
        chk("full_be_ready", 32'(be_ready), 0);
        chk("full_head_src", 32'(upd_src), 1);
        chk("full_head_pc", upd_pc, 32'h1000);
        tick();
        if3_valid = 1'b0;
        be_valid = 1'b0;
        expect_upd(1, 32'h1000, 32'hC000, 2'd3, 1);
        expect_upd(1, 32'h1004, 32'hC001, 2'd2, 0);
        expect_upd(1, 32'h1008, 32'hC002, 2'd1, 1);
        expect_upd(0, 32'h2000, 32'hB000, 2'd0, 0);
        expect_upd(1, 32'h100C, 32'hC003, 2'd0, 0);
        expect_upd(0, 32'h2004, 32'hB001, 2'd1, 1);
        expect_upd(0, 32'h2008, 32'hB002, 2'd2, 0);
        expect_upd(0, 32'h200C, 32'hB003, 2'd3, 1);
        upd_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("full_done_valid", 32'(upd_valid), 0);
        chk("full_done_if3_ready", 32'(if3_ready), 1);

        // Same-PC shadow drop, with stable head while stalled
        tick();
        upd_ready = 1'b0;
        drive_if3(1, 32'h200, 32'hD200, 2'd2, 1);
        drive_be(1, 32'h200, 32'hE200, 2'd1, 0);
        tick();
        drive_if3(1, 32'h220, 32'hD220, 2'd3, 0);
        drive_be(1, 32'h210, 32'hE210, 2'd0, 1);
        tick();
        if3_valid = 1'b0;
        be_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_pc", upd_pc, 32'h200);
            chk("stall_target", upd_target, 32'hE200);
            chk("stall_src", 32'(upd_src), 1);
            tick();
        end
        expect_upd(1, 32'h200, 32'hE200, 2'd1, 0);
        expect_upd(1, 32'h210, 32'hE210, 2'd0, 1);
        expect_upd(0, 32'h220, 32'hD220, 2'd3, 0);
        upd_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("shadow_drop_cnt", 32'(drop_cnt), 1);

        // Flush of 3 queued IF3 entries plus a concurrent push
        tick();
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_if3(1, 32'h500 + 32'(4 * i), 32'hF500 + 32'(i), 2'd1, 1);
            tick();
        end
        drive_if3(1, 32'h50C, 32'hF503, 2'd1, 1);
        flush_if3 = 1'b1;
        tick();
        flush_if3 = 1'b0;
        if3_valid = 1'b0;
        @(negedge clk);
        chk("flush_upd_valid", 32'(upd_valid), 0);
        chk("flush_if3_ready", 32'(if3_ready), 1);
        chk("flush_drop_cnt", 32'(drop_cnt), 5);

        // Flush while the IF3 head is being granted: head still delivered
        tick();
        drive_if3(1, 32'h600, 32'hF600, 2'd2, 0);
        tick();
        drive_if3(1, 32'h604, 32'hF604, 2'd3, 1);
        tick();
        if3_valid = 1'b0;
        upd_ready = 1'b1;
        flush_if3 = 1'b1;
        expect_upd(0, 32'h600, 32'hF600, 2'd2, 0);
        tick();
        flush_if3 = 1'b0;
        @(negedge clk);
        chk("flushgrant_valid", 32'(upd_valid), 0);
        chk("flushgrant_drop_cnt", 32'(drop_cnt), 6);
        drain();

        // Repeated PC from IF3 while stalled
        tick();
        upd_ready = 1'b0;
        drive_if3(1, 32'h300, 32'hF300, 2'b01, 1);
        tick();
        drive_if3(1, 32'h300, 32'hF301, 2'b10, 0);
        tick();
        if3_valid = 1'b0;
        @(negedge clk);
`ifdef NLP_SCHED_COALESCE_EN
        chk("coalesce_head_bim", 32'(upd_bim), 2);
        expect_upd(0, 32'h300, 32'hF301, 2'b10, 0);
`else
        chk("dup_head_bim", 32'(upd_bim), 1);
        expect_upd(0, 32'h300, 32'hF300, 2'b01, 1);
        expect_upd(0, 32'h300, 32'hF301, 2'b10, 0);
`endif
        tick();
        upd_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("dup_done_valid", 32'(upd_valid), 0);
        chk("dup_drop_cnt", 32'(drop_cnt), 6);

        // Reset mid-stream discards queued work
        tick();
        upd_ready = 1'b0;
        drive_be(1, 32'h700, 32'hF700, 2'd1, 1);
        tick();
        drive_be(1, 32'h704, 32'hF704, 2'd1, 1);
        tick();
        be_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_upd_valid", 32'(upd_valid), 0);
        chk("rst_be_ready", 32'(be_ready), 1);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
